// File: rtl/pipe_hazard_if.sv
// Signal bundle between the pipeline stages and the hazard/sequencing controller.
// The master side is the pipeline (decode, execute, divider, bus, interrupts); the slave side is the controller.
interface pipe_hazard_if;
  logic [4:0]  id_reg1_raddr_i;
  logic [4:0]  id_reg2_raddr_i;
  logic        id_reg_we_i;
  logic [4:0]  id_reg_waddr_i;
  logic        id_div_start_i;
  logic        div_done_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        rib_hold_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        int_ack_o;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        flush_o;
  logic        div_busy_o;
  logic        div_timeout_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output id_reg1_raddr_i, id_reg2_raddr_i, id_reg_we_i, id_reg_waddr_i, id_div_start_i,
           div_done_i, ex_jump_flag_i, ex_jump_addr_i, rib_hold_i, int_assert_i, int_addr_i,
    input  int_ack_o, hold_flag_o, jump_flag_o, jump_addr_o, flush_o, div_busy_o,
           div_timeout_o, stall_cnt_o
  );

  modport slave (
    input  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_we_i, id_reg_waddr_i, id_div_start_i,
           div_done_i, ex_jump_flag_i, ex_jump_addr_i, rib_hold_i, int_assert_i, int_addr_i,
    output int_ack_o, hold_flag_o, jump_flag_o, jump_addr_o, flush_o, div_busy_o,
           div_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: hold arbitration, PC redirect/flush and a one-entry divide scoreboard.
// Optional HAZARD_PERF_EN builds a 32-bit counter of cycles spent in a full decode stall.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DIV_TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  pipe_hazard_if.slave bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIV_PEND = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WD_LIMIT   = 8'(DIV_TIMEOUT);

  logic [1:0] state, state_nxt;
  logic       pend_valid, pend_valid_nxt;
  logic [4:0] pend_rd;
  logic [2:0] flush_cnt;
  logic [7:0] wdog;
  logic       div_timeout;

  logic       int_accept, redirect, flush, raw, waw, haz, div_set, div_clr;
  logic [2:0] hold_flag;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == WD_LIMIT) ? v : v + 8'd1;
  endfunction

  always_comb begin
    int_accept = bus.int_assert_i & ~pend_valid;
    redirect   = int_accept | bus.ex_jump_flag_i;
    flush      = redirect | (flush_cnt != 3'd0);
    raw        = ((bus.id_reg1_raddr_i != 5'd0) && (bus.id_reg1_raddr_i == pend_rd)) ||
                 ((bus.id_reg2_raddr_i != 5'd0) && (bus.id_reg2_raddr_i == pend_rd));
    waw        = bus.id_reg_we_i && (bus.id_reg_waddr_i == pend_rd) && (pend_rd != 5'd0);
    // A writeback in this very cycle frees the register, so decode may proceed.
    haz        = pend_valid & ~bus.div_done_i & (raw | waw | bus.id_div_start_i);
    div_set    = bus.id_div_start_i & ~haz & ~redirect & ~flush & ~bus.rib_hold_i;
    div_clr    = bus.div_done_i & pend_valid;
    pend_valid_nxt = div_set | (pend_valid & ~div_clr);
    if (redirect)             hold_flag = 3'd0;
    else if (bus.rib_hold_i)  hold_flag = 3'd1;
    else if (haz)             hold_flag = 3'd3;
    else                      hold_flag = 3'd0;
  end

  assign bus.int_ack_o     = int_accept;
  assign bus.jump_flag_o   = redirect;
  assign bus.jump_addr_o   = int_accept ? bus.int_addr_i :
                             bus.ex_jump_flag_i ? bus.ex_jump_addr_i : 32'd0;
  assign bus.flush_o       = flush;
  assign bus.hold_flag_o   = hold_flag;
  assign bus.div_busy_o    = pend_valid;
  assign bus.div_timeout_o = div_timeout;

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:     if (div_set) state_nxt = S_DIV_PEND;
        S_DIV_PEND: if (div_clr && !div_set) state_nxt = S_IDLE;
        S_FLUSH:    if (flush_cnt == 3'd0) state_nxt = pend_valid_nxt ? S_DIV_PEND : S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // ---- registered control, scoreboard and watchdog ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pend_valid  <= 1'b0;
      pend_rd     <= 5'd0;
      flush_cnt   <= 3'd0;
      wdog        <= 8'd0;
      div_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      if (div_set) pend_rd <= bus.id_reg_waddr_i;
      if (redirect)
        flush_cnt <= FLUSH_LOAD;
      else if (state == S_FLUSH && flush_cnt != 3'd0)
        flush_cnt <= flush_cnt - 3'd1;
      if (div_set || div_clr) begin
        wdog <= 8'd0;
      end else if (pend_valid) begin
        wdog <= sat_inc(wdog);
        if (wdog == WD_LIMIT - 8'd1) div_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     stall_cnt <= 32'd0;
    else if (hold_flag == 3'd3)  stall_cnt <= stall_cnt + 32'd1;
  end
  assign bus.stall_cnt_o = stall_cnt;
`else
  assign bus.stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int FC = 3;
  localparam int DT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_if b ();
  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .DIV_TIMEOUT(DT)) dut (.clk(clk), .rst(rst), .bus(b));

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit          m_pend;
  logic [4:0]  m_rd;
  int          m_flush_left;
  int          m_wd;
  bit          m_to;
  logic [31:0] m_stall;
  // expected outputs for the current inputs
  bit          e_ack, e_jump, e_flush, e_haz, e_rec;
  logic [2:0]  e_hold;
  logic [31:0] e_addr;

  task automatic model_reset();
    m_pend = 0; m_rd = '0; m_flush_left = 0; m_wd = 0; m_to = 0; m_stall = '0;
  endtask

  task automatic model_eval();
    bit dep;
    e_ack   = b.int_assert_i && !m_pend;
    e_jump  = e_ack || b.ex_jump_flag_i;
    e_addr  = e_ack ? b.int_addr_i : (b.ex_jump_flag_i ? b.ex_jump_addr_i : 32'd0);
    e_flush = e_jump || (m_flush_left > 0);
    dep = (b.id_reg1_raddr_i != 0 && b.id_reg1_raddr_i == m_rd) ||
          (b.id_reg2_raddr_i != 0 && b.id_reg2_raddr_i == m_rd) ||
          (b.id_reg_we_i && b.id_reg_waddr_i == m_rd && m_rd != 0) || b.id_div_start_i;
    e_haz  = m_pend && !b.div_done_i && dep;
    e_hold = e_jump ? 3'd0 : b.rib_hold_i ? 3'd1 : e_haz ? 3'd3 : 3'd0;
    e_rec  = b.id_div_start_i && !e_haz && !e_jump && !e_flush && !b.rib_hold_i;
  endtask

  task automatic model_update();
    bit done, was_pend;
    model_eval();
    was_pend = m_pend;
    done = b.div_done_i && m_pend;
    if (e_rec) begin m_pend = 1; m_rd = b.id_reg_waddr_i; end
    else if (done) m_pend = 0;
    if (e_jump) m_flush_left = FC - 1;
    else if (m_flush_left > 0) m_flush_left--;
    if (e_rec || done) m_wd = 0;
    else if (was_pend) begin
      m_wd++;
      if (m_wd >= DT) m_to = 1;
    end
`ifdef HAZARD_PERF_EN
    if (e_hold == 3'd3) m_stall = m_stall + 32'd1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic clr_inputs();
    b.id_reg1_raddr_i = '0; b.id_reg2_raddr_i = '0; b.id_reg_we_i = 0; b.id_reg_waddr_i = '0;
    b.id_div_start_i = 0; b.div_done_i = 0; b.ex_jump_flag_i = 0; b.ex_jump_addr_i = '0;
    b.rib_hold_i = 0; b.int_assert_i = 0; b.int_addr_i = '0;
  endtask

  task automatic apply_reset();
    clr_inputs();
    rst = 1;
    model_reset();
    tick(); tick();
    rst = 0;
  endtask

  task automatic start_div(input logic [4:0] rd);
    clr_inputs();
    b.id_div_start_i = 1; b.id_reg_we_i = 1; b.id_reg_waddr_i = rd;
    settle();
    tick();
    clr_inputs();
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1;
    model_reset();
    #3;
    n_vec++;
    if ({b.int_ack_o, b.hold_flag_o, b.jump_flag_o, b.jump_addr_o, b.flush_o, b.div_busy_o,
         b.div_timeout_o, b.stall_cnt_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs: busy=%0b hold=%0d timeout=%0b stall=%0d, required all 0",
                        b.div_busy_o, b.hold_flag_o, b.div_timeout_o, b.stall_cnt_o);
    end
    tick(); rst = 0; tick();
    start_div(5'd7);
    settle();
    n_vec++;
    if (b.div_busy_o !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_busy: got %0b, required 1", b.div_busy_o);
    end
    rst = 1;
    model_reset();
    #1;
    tick();
    n_vec++;
    if (b.div_busy_o !== 1'b0 || b.hold_flag_o !== 3'd0 || b.flush_o !== 1'b0 || b.jump_flag_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_div: busy=%0b hold=%0d flush=%0b jump=%0b, required 0",
                        b.div_busy_o, b.hold_flag_o, b.flush_o, b.jump_flag_o);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_raw_hazard();
    start_div(5'd5);
    b.id_reg1_raddr_i = 5'd5;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_vec++;
      if (b.hold_flag_o !== 3'd3) begin
        n_err++; $display("FAIL raw_stall[%0d]: hold=%0d, required 3", i, b.hold_flag_o);
      end
      tick();
    end
    b.div_done_i = 1;
    settle();
    n_vec++;
    if (b.hold_flag_o !== 3'd0) begin
      n_err++; $display("FAIL raw_done_bypass: hold=%0d, required 0", b.hold_flag_o);
    end
    tick();
    start_div(5'd0);
    b.id_reg_we_i = 1; b.id_reg_waddr_i = 5'd0;
    settle();
    n_vec++;
    if (b.hold_flag_o !== 3'd0 || b.div_busy_o !== 1'b1) begin
      n_err++; $display("FAIL raw_x0_nostall: hold=%0d busy=%0b, required 0/1", b.hold_flag_o, b.div_busy_o);
    end
    clr_inputs(); b.div_done_i = 1; settle(); tick(); clr_inputs();
  endtask

  task automatic test_back_to_back();
    start_div(5'd3);
    b.id_div_start_i = 1; b.id_reg_we_i = 1; b.id_reg_waddr_i = 5'd9;
    settle();
    n_vec++;
    if (b.hold_flag_o !== 3'd3) begin
      n_err++; $display("FAIL b2b_held: hold=%0d, required 3", b.hold_flag_o);
    end
    tick();
    b.div_done_i = 1;
    settle();
    n_vec++;
    if (b.hold_flag_o !== 3'd0) begin
      n_err++; $display("FAIL b2b_release: hold=%0d, required 0", b.hold_flag_o);
    end
    tick();
    clr_inputs();
    b.id_reg1_raddr_i = 5'd9;
    settle();
    n_vec++;
    if (b.div_busy_o !== 1'b1 || b.hold_flag_o !== 3'd3) begin
      n_err++; $display("FAIL b2b_new_rd: busy=%0b hold=%0d, required 1/3", b.div_busy_o, b.hold_flag_o);
    end
    b.id_reg1_raddr_i = 5'd3;
    settle();
    n_vec++;
    if (b.hold_flag_o !== 3'd0) begin
      n_err++; $display("FAIL b2b_old_rd: hold=%0d, required 0", b.hold_flag_o);
    end
    clr_inputs(); b.div_done_i = 1; settle(); tick(); clr_inputs();
  endtask

  task automatic test_int_vs_div();
    int fcnt;
    start_div(5'd4);
    b.int_assert_i = 1; b.int_addr_i = 32'h80;
    settle();
    n_vec++;
    if (b.int_ack_o !== 1'b0 || b.jump_flag_o !== 1'b0) begin
      n_err++; $display("FAIL int_held: ack=%0b jump=%0b, required 0/0", b.int_ack_o, b.jump_flag_o);
    end
    tick();
    b.div_done_i = 1;
    settle();
    n_vec++;
    if (b.int_ack_o !== 1'b0) begin
      n_err++; $display("FAIL int_held_done_cycle: ack=%0b, required 0", b.int_ack_o);
    end
    tick();
    b.div_done_i = 0;
    settle();
    n_vec++;
    if (b.int_ack_o !== 1'b1 || b.jump_addr_o !== 32'h80 || b.flush_o !== 1'b1) begin
      n_err++; $display("FAIL int_accept: ack=%0b addr=%h flush=%0b, required 1/80/1",
                        b.int_ack_o, b.jump_addr_o, b.flush_o);
    end
    fcnt = b.flush_o ? 1 : 0;
    tick();
    clr_inputs();
    for (int i = 0; i < 10; i++) begin
      settle();
      if (b.flush_o === 1'b1) fcnt++;
      tick();
    end
    n_vec++;
    if (fcnt != FC) begin
      n_err++; $display("FAIL int_flush_len: %0d cycles, required %0d", fcnt, FC);
    end
  endtask

  task automatic test_jump_hold_div();
    clr_inputs();
    b.ex_jump_flag_i = 1; b.ex_jump_addr_i = 32'h100; b.rib_hold_i = 1;
    b.id_div_start_i = 1; b.id_reg_we_i = 1; b.id_reg_waddr_i = 5'd6;
    settle();
    n_vec++;
    if (b.jump_flag_o !== 1'b1 || b.hold_flag_o !== 3'd0 || b.jump_addr_o !== 32'h100) begin
      n_err++; $display("FAIL jump_combo: jump=%0b hold=%0d addr=%h, required 1/0/100",
                        b.jump_flag_o, b.hold_flag_o, b.jump_addr_o);
    end
    tick();
    clr_inputs();
    for (int i = 0; i < FC + 1; i++) begin settle(); tick(); end
    settle();
    n_vec++;
    if (b.div_busy_o !== 1'b0) begin
      n_err++; $display("FAIL jump_div_dropped: busy=%0b, required 0", b.div_busy_o);
    end
  endtask

  task automatic test_watchdog();
    int hcnt = 0;
    logic [31:0] exp_stall;
    apply_reset();
    start_div(5'd2);
    for (int k = 1; k <= DT; k++) begin
      b.id_reg1_raddr_i = (k >= 10 && k < 20) ? 5'd2 : 5'd0;
      settle();
      if (b.hold_flag_o === 3'd3) hcnt++;
      tick();
      if (k == DT - 1) begin
        n_vec++;
        if (b.div_timeout_o !== 1'b0) begin
          n_err++; $display("FAIL wd_early: timeout=%0b after %0d cycles, required 0", b.div_timeout_o, k);
        end
      end
    end
    n_vec++;
    if (b.div_timeout_o !== 1'b1) begin
      n_err++; $display("FAIL wd_fire: timeout=%0b, required 1", b.div_timeout_o);
    end
`ifdef HAZARD_PERF_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif
    n_vec++;
    if (b.stall_cnt_o !== exp_stall || hcnt != 10) begin
      n_err++; $display("FAIL wd_stall_cnt: cnt=%0d hold3_cycles=%0d, required %0d/10", b.stall_cnt_o, hcnt, exp_stall);
    end
    clr_inputs(); b.div_done_i = 1; settle(); tick(); clr_inputs();
    settle();
    n_vec++;
    if (b.div_timeout_o !== 1'b1 || b.div_busy_o !== 1'b0) begin
      n_err++; $display("FAIL wd_sticky: timeout=%0b busy=%0b, required 1/0", b.div_timeout_o, b.div_busy_o);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      b.id_reg1_raddr_i = 5'($urandom_range(0, 7));
      b.id_reg2_raddr_i = 5'($urandom_range(0, 7));
      b.id_reg_we_i     = ($urandom_range(0, 1) == 1);
      b.id_reg_waddr_i  = 5'($urandom_range(0, 7));
      b.id_div_start_i  = ($urandom_range(0, 9) < 3);
      b.div_done_i      = ($urandom_range(0, 9) < 2);
      b.ex_jump_flag_i  = ($urandom_range(0, 19) == 0);
      b.ex_jump_addr_i  = $urandom;
      b.rib_hold_i      = ($urandom_range(0, 9) == 0);
      b.int_assert_i    = ($urandom_range(0, 9) == 0);
      b.int_addr_i      = $urandom;
      settle();
      n_vec++;
      if (b.int_ack_o !== e_ack || b.jump_flag_o !== e_jump || b.jump_addr_o !== e_addr) begin
        n_err++; $display("FAIL rnd_redirect[%0d]: ack=%0b jump=%0b addr=%h, required %0b/%0b/%h",
                          i, b.int_ack_o, b.jump_flag_o, b.jump_addr_o, e_ack, e_jump, e_addr);
      end
      n_vec++;
      if (b.hold_flag_o !== e_hold || b.flush_o !== e_flush) begin
        n_err++; $display("FAIL rnd_hold_flush[%0d]: hold=%0d flush=%0b, required %0d/%0b",
                          i, b.hold_flag_o, b.flush_o, e_hold, e_flush);
      end
      n_vec++;
      if (b.div_busy_o !== m_pend || b.div_timeout_o !== m_to || b.stall_cnt_o !== m_stall) begin
        n_err++; $display("FAIL rnd_state[%0d]: busy=%0b timeout=%0b stall=%0d, required %0b/%0b/%0d",
                          i, b.div_busy_o, b.div_timeout_o, b.stall_cnt_o, m_pend, m_to, m_stall);
      end
      tick();
    end
    clr_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr_inputs();
    model_reset();
    test_reset();
    test_raw_hazard();
    test_back_to_back();
    test_int_vs_div();
    test_jump_hold_div();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
